// File: rtl/fifo_pkg.sv
// Shared FIFO constants and width helpers.
// Used by sync_fifo_fwft and sync_fifo_mem.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Pointer width for an n-entry array.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Count width able to hold 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DATA_WIDTH x FIFO_DEPTH, sync write, comb read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PW         = ptr_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO, any depth, optional first-word-fall-through.
// Ports: CLK, RST(async low), W_INC/WR_DATA, R_INC, FLUSH; RD_DATA,
// RD_VALID, FULL, EMPTY, ALMOST_FULL/EMPTY, COUNT, OVERFLOW, UNDERFLOW.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int CW           = cnt_w(FIFO_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  input  logic                  FLUSH,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [CW-1:0]         COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int PW = ptr_w(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 ||
      AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1 ||
      (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT))
  begin : g_param_err
    $error("sync_fifo_fwft: illegal parameter value");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  // Wrap at FIFO_DEPTH-1; depth need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Flush wins: concurrent requests are dropped silently.
  assign wr_ok = W_INC && !full && !FLUSH;
  assign rd_ok = R_INC && !empty && !FLUSH;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PW         (PW)
  ) u_mem (
    .clk   (CLK),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (WR_DATA),
    .raddr (rd_ptr),
    .rdata (mem_rd)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (FLUSH) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= nxt(wr_ptr);
      if (rd_ok) rd_ptr <= nxt(rd_ptr);
      if (wr_ok && !rd_ok)
        count_q <= count_q + 1'b1;
      else if (rd_ok && !wr_ok)
        count_q <= count_q - 1'b1;
      if (W_INC && full)  ovf_q <= 1'b1;
      if (R_INC && empty) unf_q <= 1'b1;
      rvalid_q <= rd_ok;
      if (rd_ok) rdata_q <= mem_rd;
    end
  end

  // FWFT shows the head word directly; zero while empty.
  assign RD_DATA = (FWFT == FIFO_MODE_FWFT) ?
                   (empty ? '0 : mem_rd) : rdata_q;
  assign RD_VALID = (FWFT == FIFO_MODE_FWFT) ? !empty : rvalid_q;

  assign FULL         = full;
  assign EMPTY        = empty;
  assign ALMOST_FULL  = (count_q >= CW'(AFULL_THRESH));
  assign ALMOST_EMPTY = (count_q <= CW'(AEMPTY_THRESH));
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench: STD and FWFT instances driven in lockstep,
// checked against a queue model.
module tb_sync_fifo_fwft;

  localparam int DEPTH = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       W_INC = 1'b0;
  logic [7:0] WR_DATA = '0;
  logic       R_INC = 1'b0;
  logic       FLUSH = 1'b0;

  logic [7:0] s_rd, f_rd;
  logic       s_rv, f_rv, s_full, f_full, s_empty, f_empty;
  logic       s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
  logic [2:0] s_cnt, f_cnt;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_unf, m_rv;
  logic [7:0] m_rd;

  always #5 CLK = ~CLK;

  sync_fifo_fwft #(
    .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(0),
    .AFULL_THRESH(5), .AEMPTY_THRESH(1)
  ) u_std (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA),
    .R_INC(R_INC), .FLUSH(FLUSH), .RD_DATA(s_rd), .RD_VALID(s_rv),
    .FULL(s_full), .EMPTY(s_empty), .ALMOST_FULL(s_af),
    .ALMOST_EMPTY(s_ae), .COUNT(s_cnt), .OVERFLOW(s_ovf),
    .UNDERFLOW(s_unf)
  );

  sync_fifo_fwft #(
    .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(1),
    .AFULL_THRESH(5), .AEMPTY_THRESH(1)
  ) u_fw (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA),
    .R_INC(R_INC), .FLUSH(FLUSH), .RD_DATA(f_rd), .RD_VALID(f_rv),
    .FULL(f_full), .EMPTY(f_empty), .ALMOST_FULL(f_af),
    .ALMOST_EMPTY(f_ae), .COUNT(f_cnt), .OVERFLOW(f_ovf),
    .UNDERFLOW(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
  endtask

  // Model update from pre-edge occupancy.
  task automatic model_edge(input logic w, input logic [7:0] d,
                            input logic r, input logic f);
    int n;
    n = q.size();
    if (f) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0;
    end else begin
      m_rv = 0;
      if (r && n == 0) m_unf = 1;
      if (r && n > 0) begin
        m_rd = q.pop_front();
        m_rv = 1;
      end
      if (w && n == DEPTH) m_ovf = 1;
      if (w && n < DEPTH) q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".s_cnt"},   32'(s_cnt),   32'(n));
    chk({tag, ".s_full"},  32'(s_full),  32'(n == DEPTH));
    chk({tag, ".s_empty"}, 32'(s_empty), 32'(n == 0));
    chk({tag, ".s_af"},    32'(s_af),    32'(n >= 5));
    chk({tag, ".s_ae"},    32'(s_ae),    32'(n <= 1));
    chk({tag, ".s_ovf"},   32'(s_ovf),   32'(m_ovf));
    chk({tag, ".s_unf"},   32'(s_unf),   32'(m_unf));
    chk({tag, ".s_rv"},    32'(s_rv),    32'(m_rv));
    chk({tag, ".s_rd"},    32'(s_rd),    32'(m_rd));
    chk({tag, ".f_cnt"},   32'(f_cnt),   32'(n));
    chk({tag, ".f_empty"}, 32'(f_empty), 32'(n == 0));
    chk({tag, ".f_full"},  32'(f_full),  32'(n == DEPTH));
    chk({tag, ".f_af"},    32'(f_af),    32'(n >= 5));
    chk({tag, ".f_ae"},    32'(f_ae),    32'(n <= 1));
    chk({tag, ".f_ovf"},   32'(f_ovf),   32'(m_ovf));
    chk({tag, ".f_unf"},   32'(f_unf),   32'(m_unf));
    chk({tag, ".f_rv"},    32'(f_rv),    32'(n != 0));
    if (n != 0) chk({tag, ".f_rd"}, 32'(f_rd), 32'(q[0]));
  endtask

  task automatic step(input string tag, input logic w,
                      input logic [7:0] d, input logic r,
                      input logic f);
    W_INC = w; WR_DATA = d; R_INC = r; FLUSH = f;
    @(posedge CLK);
    model_edge(w, d, r, f);
    #1;
    W_INC = 0; R_INC = 0; FLUSH = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    RST = 1'b1;
    @(posedge CLK); #1;

    // 1: async reset mid-operation
    for (int i = 0; i < 3; i++) step("t1_wr", 1, 8'(i + 1), 0, 0);
    #2 RST = 1'b0;
    #1 model_reset();
    check_all("t1_async_rst");
    @(posedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK); #1;
    step("t1_wa5", 1, 8'hA5, 0, 0);
    step("t1_ra5", 0, 8'h00, 1, 0);
    chk("t1_rd_a5", 32'(s_rd), 32'hA5);
    chk("t1_rv_pulse", 32'(s_rv), 1);
    step("t1_idle", 0, 8'h00, 0, 0);
    chk("t1_rv_drop", 32'(s_rv), 0);

    // 2: fill, overflow, drain, underflow
    for (int i = 0; i < 6; i++) step("t2_fill", 1, 8'(8'h10 + i), 0, 0);
    step("t2_ovf", 1, 8'h16, 0, 0);
    chk("t2_ovf_flag", 32'(s_ovf), 1);
    for (int i = 0; i < 6; i++) begin
      step("t2_drain", 0, 8'h00, 1, 0);
      chk("t2_order", 32'(s_rd), 32'(8'h10 + i));
    end
    step("t2_unf", 0, 8'h00, 1, 0);
    chk("t2_unf_flag", 32'(s_unf), 1);

    // 3: pointer wrap
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++)
        step("t3_wr", 1, 8'(8'h40 + 4 * k + i), 0, 0);
      for (int i = 0; i < 4; i++) begin
        step("t3_rd", 0, 8'h00, 1, 0);
        chk("t3_order", 32'(s_rd), 32'(8'h40 + 4 * k + i));
      end
      chk("t3_cnt0", 32'(s_cnt), 0);
    end

    // 4: simultaneous read+write
    step("t4_flush", 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) step("t4_wr", 1, 8'(8'h50 + i), 0, 0);
    step("t4_both3", 1, 8'h53, 1, 0);
    chk("t4_cnt3", 32'(s_cnt), 3);
    for (int i = 0; i < 3; i++) step("t4_wr", 1, 8'(8'h54 + i), 0, 0);
    step("t4_bothfull", 1, 8'h5F, 1, 0);
    chk("t4_cnt5", 32'(s_cnt), 5);
    chk("t4_ovf", 32'(s_ovf), 1);
    step("t4_flush2", 0, 8'h00, 0, 1);
    step("t4_bothempty", 1, 8'h61, 1, 0);
    chk("t4_cnt1", 32'(s_cnt), 1);
    chk("t4_unf", 32'(s_unf), 1);

    // 5: FWFT fall-through
    step("t5_flush", 0, 8'h00, 0, 1);
    step("t5_w3c", 1, 8'h3C, 0, 0);
    chk("t5_fw_empty", 32'(f_empty), 0);
    chk("t5_fw_rv", 32'(f_rv), 1);
    chk("t5_fw_rd", 32'(f_rd), 32'h3C);
    step("t5_pop", 0, 8'h00, 1, 0);
    chk("t5_fw_empty2", 32'(f_empty), 1);

    // 6: flush beats concurrent write
    for (int i = 0; i < 6; i++) step("t6_fill", 1, 8'(8'h20 + i), 0, 0);
    step("t6_ovf", 1, 8'h26, 0, 0);
    step("t6_rd", 0, 8'h00, 1, 0);
    step("t6_rd", 0, 8'h00, 1, 0);
    chk("t6_cnt4", 32'(s_cnt), 4);
    step("t6_flush", 1, 8'h77, 0, 1);
    chk("t6_cnt0", 32'(s_cnt), 0);
    chk("t6_ovf0", 32'(s_ovf), 0);
    step("t6_w42", 1, 8'h42, 0, 0);
    chk("t6_fw_rd", 32'(f_rd), 32'h42);
    step("t6_r42", 0, 8'h00, 1, 0);
    chk("t6_rd42", 32'(s_rd), 32'h42);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic w, r, f;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 39) == 0);
      step("rnd", w, 8'($urandom), r, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
